// File: rtl/fact_pkg.sv
// Shared definitions for the factorial unit register map and its host sequencer.
package fact_pkg;

    localparam logic [1:0] FACT_A_N    = 2'd0;
    localparam logic [1:0] FACT_A_GO   = 2'd1;
    localparam logic [1:0] FACT_A_STAT = 2'd2;
    localparam logic [1:0] FACT_A_RES  = 2'd3;

    localparam int unsigned STAT_DONE = 0;
    localparam int unsigned STAT_ERR  = 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_N,
        WR_GO,
        POLL,
        RD_RES,
        RESP
    } fact_state_e;

endpackage

// File: rtl/fact_poll_timer.sv
// Poll cycle counter: cleared before polling starts, flags the last allowed poll cycle.
module fact_poll_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [TW-1:0] count_q;

    assign tc = (count_q == TW'(TIMEOUT_CYCLES - 1));

    // Saturates at the terminal count; the sequencer leaves POLL on that cycle anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && !tc) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/fact_host_seq.sv
// Command sequencer: turns a factorial request into the register-bus sequence of the
// factorial unit and returns result/error/timeout on a valid/ready response channel.
module fact_host_seq
    import fact_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    localparam int unsigned TW            = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_n,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [1:0]  A,
    output logic        WE,
    output logic [3:0]  WD,
    input  logic [31:0] RD
);

    fact_state_e state_q, state_d;
    logic        poll_tc;

    logic [1:0]  a_d;
    logic        we_d;
    logic [3:0]  wd_d;
    logic        rsp_valid_d;
    logic [31:0] rsp_result_d;
    logic        rsp_err_d;
    logic        rsp_timeout_d;
    logic        busy_d;

    fact_poll_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TW            (TW)
    ) u_poll_timer (
        .clk(clk),
        .rst(rst),
        .clr(state_q == WR_GO),
        .en (state_q == POLL),
        .tc (poll_tc)
    );

    assign req_ready = (state_q == IDLE);

    // State and all bus/response outputs are registered together, so the bus always
    // reflects the current state and RD is sampled in the cycle its address is driven.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            A           <= FACT_A_N;
            WE          <= 1'b0;
            WD          <= 4'd0;
            rsp_valid   <= 1'b0;
            rsp_result  <= 32'd0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            A           <= a_d;
            WE          <= we_d;
            WD          <= wd_d;
            rsp_valid   <= rsp_valid_d;
            rsp_result  <= rsp_result_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
            busy        <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid) state_d = WR_N;
            WR_N:    state_d = WR_GO;
            WR_GO:   state_d = POLL;
            POLL: begin
                if (RD[STAT_ERR]) begin
                    state_d = RESP;
                end else if (RD[STAT_DONE]) begin
                    state_d = RD_RES;
                end else if (poll_tc) begin
                    state_d = RESP;
                end
            end
            RD_RES:  state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d         = FACT_A_N;
        we_d        = 1'b0;
        wd_d        = 4'd0;
        rsp_valid_d = 1'b0;
        busy_d      = (state_d != IDLE);
        unique case (state_d)
            // WR_N is only entered from IDLE, so the WD register is what latches req_n.
            WR_N: begin
                a_d  = FACT_A_N;
                we_d = 1'b1;
                wd_d = req_n;
            end
            WR_GO: begin
                a_d  = FACT_A_GO;
                we_d = 1'b1;
                wd_d = 4'b0001;
            end
            POLL:    a_d = FACT_A_STAT;
            RD_RES:  a_d = FACT_A_RES;
            RESP:    rsp_valid_d = 1'b1;
            default: a_d = FACT_A_N;
        endcase
    end

    always_comb begin
        rsp_result_d  = rsp_result;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;
        if (state_q == POLL) begin
            if (RD[STAT_ERR]) begin
                rsp_result_d  = 32'd0;
                rsp_err_d     = 1'b1;
                rsp_timeout_d = 1'b0;
            end else if (!RD[STAT_DONE] && poll_tc) begin
                rsp_result_d  = 32'd0;
                rsp_err_d     = 1'b0;
                rsp_timeout_d = 1'b1;
            end
        end else if (state_q == RD_RES) begin
            rsp_result_d  = RD;
            rsp_err_d     = 1'b0;
            rsp_timeout_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_fact_host_seq.sv
// Bench for fact_host_seq: behavioural factorial unit stub plus a transaction-level
// reference model; directed cases followed by randomized requests.
module tb_fact_host_seq;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_n;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        busy;
    logic [1:0]  A;
    logic        WE;
    logic [3:0]  WD;
    logic [31:0] RD;

    int n_tests = 0;
    int n_fail  = 0;

    // Stub configuration: status appears once cfg_lat polls have gone unanswered.
    int unsigned cfg_lat  = 0;
    bit          cfg_ferr = 1'b0;
    bit          cfg_both = 1'b0;

    logic [3:0]  u_n;
    int unsigned u_polls;
    logic [1:0]  u_stat;

    fact_host_seq #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_n      (req_n),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .A          (A),
        .WE         (WE),
        .WD         (WD),
        .RD         (RD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fact(input logic [3:0] n);
        logic [31:0] r = 32'd1;
        for (int i = 2; i <= int'(n); i++) r = r * i;
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u_n     <= 4'd0;
            u_polls <= 0;
        end else begin
            if (WE && A == 2'd0) u_n <= WD;
            if (WE && A == 2'd1 && WD[0]) u_polls <= 0;
            else if (!WE && A == 2'd2) u_polls <= u_polls + 1;
        end
    end

    always_comb begin
        u_stat = 2'b00;
        if (u_polls >= cfg_lat) begin
            if (cfg_ferr || u_n > 4'd12) u_stat = cfg_both ? 2'b11 : 2'b10;
            else u_stat = 2'b01;
        end
        case (A)
            2'd0:    RD = {28'd0, u_n};
            2'd1:    RD = 32'd0;
            2'd2:    RD = {30'd0, u_stat};
            default: RD = (cfg_ferr || u_n > 4'd12) ? 32'hDEAD_BEEF : fact(u_n);
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected outcome of one request from the unit's behaviour alone.
    function automatic void ref_model(input logic [3:0] n, input int unsigned lat,
                                      input bit ferr, output logic [31:0] r, output bit e,
                                      output bit t, output int unsigned polls,
                                      output int unsigned reads);
        if (lat >= TMO) begin
            r = 0; e = 0; t = 1; polls = TMO; reads = 0;
        end else if (ferr || n > 4'd12) begin
            r = 0; e = 1; t = 0; polls = lat + 1; reads = 0;
        end else begin
            r = fact(n); e = 0; t = 0; polls = lat + 1; reads = 1;
        end
    endfunction

    task automatic run_txn(input logic [3:0] n, input int unsigned lat, input bit ferr,
                           input bit both, input int unsigned hold);
        logic [31:0] er;
        bit          ee, et, seen, bad, unstable;
        int unsigned ep, erd, c, polls, reads, waits;
        ref_model(n, lat, ferr, er, ee, et, ep, erd);
        cfg_lat  = lat;
        cfg_ferr = ferr;
        cfg_both = both;
        waits = 0;
        while (!req_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        check("req_ready_before_accept", req_ready, 1);
        req_n     = n;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        // During a held response keep offering a request to prove it is not taken early.
        req_valid = (hold != 0);
        c = 1; polls = 0; reads = 0; bad = 0; seen = 0;
        while (!seen && c <= 40) begin
            if (rsp_valid) begin
                seen = 1;
            end else begin
                if (req_ready || !busy) bad = 1;
                if (c == 1) check("wr_n_bus", {A, WE, WD}, {2'd0, 1'b1, n});
                else if (c == 2) check("wr_go_bus", {A, WE, WD}, {2'd1, 1'b1, 4'd1});
                else if (A == 2'd2 && !WE && reads == 0) polls++;
                else if (A == 2'd3 && !WE) reads++;
                else bad = 1;
                @(negedge clk);
                c++;
            end
        end
        check("rsp_valid_seen", seen, 1);
        check("busy_no_ready_during_txn", bad, 0);
        check("poll_cycles", polls, ep);
        check("result_reads", reads, erd);
        check("latency", c, 3 + ep + erd);
        check("rsp_result", rsp_result, er);
        check("rsp_err", rsp_err, ee);
        check("rsp_timeout", rsp_timeout, et);
        unstable = 0;
        for (int i = 0; i < int'(hold); i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_result !== er || rsp_err !== ee || rsp_timeout !== et ||
                req_ready || !busy || A != 2'd0 || WE)
                unstable = 1;
        end
        if (hold != 0) check("resp_held_stable", unstable, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("after_handshake_rsp_valid", rsp_valid, 0);
        check("after_handshake_idle", {req_ready, busy}, 2'b10);
        check("result_held_after_handshake", rsp_result, er);
    endtask

    initial begin
        int waits;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_n     = 4'd0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_req_ready", req_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_bus", {A, WE, WD}, 7'd0);
        check("reset_rsp", {rsp_result, rsp_err, rsp_timeout}, 34'd0);
        rst = 1'b0;
        @(negedge clk);

        run_txn(4'd5, 0, 0, 0, 0);
        run_txn(4'd5, 1, 0, 0, 0);
        run_txn(4'd0, 0, 0, 0, 0);
        run_txn(4'd12, 3, 0, 0, 0);
        run_txn(4'd6, 2, 1, 0, 0);
        run_txn(4'd4, 1, 1, 1, 0);
        run_txn(4'd9, 100, 0, 0, 0);
        run_txn(4'd7, 0, 0, 0, 20);
        run_txn(4'd13, 0, 0, 0, 0);
        run_txn(4'd10, 7, 0, 0, 0);

        // Reset in the middle of polling.
        cfg_lat   = 50;
        cfg_ferr  = 0;
        cfg_both  = 0;
        req_n     = 4'd9;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        waits = 0;
        while (A != 2'd2 && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        check("reach_poll_before_rst", A, 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midpoll_rst_busy", busy, 0);
        check("midpoll_rst_rsp_valid", rsp_valid, 0);
        check("midpoll_rst_bus", {A, WE}, 3'd0);
        check("midpoll_rst_req_ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_txn(4'd3, 0, 0, 0, 0);

        for (int k = 0; k < 40; k++) begin
            run_txn(4'($urandom_range(0, 15)), $urandom_range(0, 10),
                    $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
